z80_daisy_intctl: RTL and testbench

//  Peripheral-side Z80 mode-2 interrupt responder for one daisy-chained device (CTC/PIO/SIO style).

---
 rtl/z80_daisy_intctl_if.sv | 28 ++
 rtl/z80_daisy_intctl.sv | 107 ++++++++++
 tb/tb_z80_daisy_intctl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_daisy_intctl_if.sv
// CPU-side and daisy-chain signals of one mode-2 interrupting device.
// The master modport drives the CPU/bus side; the slave modport is the responder.
interface z80_daisy_intctl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] I_REQ;
    logic [NUM_CH-1:0] I_CLR;
    logic              I_VEC_WR;
    logic [7:0]        I_VD;
    logic              I_IEI;
    logic              I_M1_n;
    logic              I_SPM1;
    logic              I_RETI;
    logic              O_INT_n;
    logic              O_IEO;
    logic [7:0]        O_D;
    logic              O_DOE;

    modport master (
        output I_REQ, I_CLR, I_VEC_WR, I_VD, I_IEI, I_M1_n, I_SPM1, I_RETI,
        input  O_INT_n, O_IEO, O_D, O_DOE
    );

    modport slave (
        input  I_REQ, I_CLR, I_VEC_WR, I_VD, I_IEI, I_M1_n, I_SPM1, I_RETI,
        output O_INT_n, O_IEO, O_D, O_DOE
    );
endinterface

// File: rtl/z80_daisy_intctl.sv
// Z80 mode-2 daisy-chain interrupt responder: per-channel pending/in-service
// tracking, IEI/IEO chaining, vector answer on acknowledge and RETI clearing.
//
// state    | meaning
// ST_IDLE  | no acknowledge in progress, a new SPM1 may be answered
// ST_ACK   | vector being driven for the current SPM1, wait for SPM1 to drop
module z80_daisy_intctl #(
    parameter int          NUM_CH    = 4,
    parameter logic [7:0]  VEC_RESET = 8'h00
) (
    input  logic                 I_CLK,
    input  logic                 I_RESET_n,
    input  logic                 I_CLKEN,
    z80_daisy_intctl_if.slave    bus
);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ack_act;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] serv;
    logic [NUM_CH-1:0] req_r;
    logic [NUM_CH-1:0] pend_nxt;
    logic [NUM_CH-1:0] serv_nxt;
    logic [4:0]        vbase;
    logic [1:0]        ack_ch;
    logic [1:0]        hp;
    logic [1:0]        hs;
    logic              any_pend;
    logic              any_serv;
    logic              eligible;
    logic              ack_go;
    logic              reti_go;

    // Lowest index wins, so scan from the top and let lower channels overwrite.
    always_comb begin
        hp = '0;
        hs = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) hp = 2'(i);
            if (serv[i]) hs = 2'(i);
        end
    end

    assign any_pend = |pend;
    assign any_serv = |serv;
    assign eligible = any_pend & (~any_serv | (hp < hs));
    assign ack_go   = bus.I_SPM1 & (state == ST_IDLE) & bus.I_IEI & eligible;
    assign reti_go  = bus.I_RETI & bus.I_IEI & any_serv;

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            state <= ST_IDLE;
        end else if (I_CLKEN) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ack_go)       state_nxt = ST_ACK;
            ST_ACK:  if (!bus.I_SPM1)  state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_act = (state == ST_ACK);
    end

    // RETI retires the pre-cycle highest in-service channel before the ack marks its own.
    always_comb begin
        pend_nxt = (pend | (bus.I_REQ & ~req_r)) & ~bus.I_CLR;
        serv_nxt = serv;
        if (reti_go) serv_nxt[hs] = 1'b0;
        if (ack_go) begin
            pend_nxt[hp] = 1'b0;
            serv_nxt[hp] = 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            pend   <= '0;
            serv   <= '0;
            req_r  <= '0;
            vbase  <= VEC_RESET[7:3];
            ack_ch <= '0;
        end else if (I_CLKEN) begin
            req_r <= bus.I_REQ;
            pend  <= pend_nxt;
            serv  <= serv_nxt;
            if (bus.I_VEC_WR) vbase  <= bus.I_VD[7:3];
            if (ack_go)       ack_ch <= hp;
        end
    end

    assign bus.O_INT_n = ~(bus.I_IEI & eligible);
    assign bus.O_IEO   = bus.I_IEI & ~any_serv & ~(any_pend & ~bus.I_M1_n);
    assign bus.O_DOE   = bus.I_SPM1 & ack_act;
    assign bus.O_D     = {vbase, ack_ch, 1'b0};

endmodule

// File: tb/tb_z80_daisy_intctl.sv
// Bench for z80_daisy_intctl: directed vector table, hand sequences for reset and
// RETI/ack corner cases, then random traffic against a behavioural model.
module tb_z80_daisy_intctl;

    localparam int         NUM_CH    = 4;
    localparam logic [7:0] VEC_RESET = 8'h48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clken = 1'b0;

    always #5 clk = ~clk;

    z80_daisy_intctl_if #(.NUM_CH(NUM_CH)) bus ();

    z80_daisy_intctl #(.NUM_CH(NUM_CH), .VEC_RESET(VEC_RESET)) dut (
        .I_CLK     (clk),
        .I_RESET_n (rst_n),
        .I_CLKEN   (clken),
        .bus       (bus)
    );

    typedef struct {
        logic       clken;
        logic [3:0] req;
        logic [3:0] clr;
        logic       vec_wr;
        logic [7:0] vd;
        logic       iei;
        logic       m1_n;
        logic       spm1;
        logic       reti;
        logic       e_int_n;
        logic       e_ieo;
        logic       e_doe;
        logic [7:0] e_d;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: sets of pending / in-service channels as bit arrays.
    bit mpend [4];
    bit mserv [4];
    bit mreq  [4];
    int mvbase;
    int mack_ch;
    bit mack;

    function automatic vec_t mk(logic ce, logic [3:0] req, logic [3:0] clr, logic vw,
                                logic [7:0] vd, logic iei, logic m1_n, logic spm1,
                                logic reti, logic e_int_n, logic e_ieo, logic e_doe,
                                logic [7:0] e_d);
        vec_t v;
        v.clken = ce; v.req = req; v.clr = clr; v.vec_wr = vw; v.vd = vd;
        v.iei = iei; v.m1_n = m1_n; v.spm1 = spm1; v.reti = reti;
        v.e_int_n = e_int_n; v.e_ieo = e_ieo; v.e_doe = e_doe; v.e_d = e_d;
        return v;
    endfunction

    function automatic vec_t mk_in(logic [3:0] req, logic iei, logic m1_n,
                                   logic spm1, logic reti);
        return mk(1'b1, req, 4'h0, 1'b0, 8'h00, iei, m1_n, spm1, reti,
                  1'b0, 1'b0, 1'b0, 8'h00);
    endfunction

    function automatic int first_of(bit a [4]);
        for (int i = 0; i < 4; i++) if (a[i]) return i;
        return 99;
    endfunction

    task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(vec_t v);
        clken        = v.clken;
        bus.I_REQ    = v.req;
        bus.I_CLR    = v.clr;
        bus.I_VEC_WR = v.vec_wr;
        bus.I_VD     = v.vd;
        bus.I_IEI    = v.iei;
        bus.I_M1_n   = v.m1_n;
        bus.I_SPM1   = v.spm1;
        bus.I_RETI   = v.reti;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mpend[c] = 1'b0; mserv[c] = 1'b0; mreq[c] = 1'b0;
        end
        mvbase  = int'(VEC_RESET) / 8;
        mack_ch = 0;
        mack    = 1'b0;
    endtask

    task automatic model_update();
        int hp, hs;
        bit elig, do_ack, do_reti;
        bit np [4];
        bit ns [4];
        if (!rst_n || !clken) return;
        hp      = first_of(mpend);
        hs      = first_of(mserv);
        elig    = (hp != 99) && (hp < hs);
        do_ack  = bus.I_SPM1 && !mack && bus.I_IEI && elig;
        do_reti = bus.I_RETI && bus.I_IEI && (hs != 99);
        for (int c = 0; c < 4; c++) begin
            np[c] = mpend[c] || (bus.I_REQ[c] && !mreq[c]);
            if (bus.I_CLR[c]) np[c] = 1'b0;
            ns[c] = mserv[c];
        end
        if (do_reti) ns[hs] = 1'b0;
        if (do_ack) begin
            np[hp]  = 1'b0;
            ns[hp]  = 1'b1;
            mack_ch = hp;
        end
        if (do_ack)           mack = 1'b1;
        else if (!bus.I_SPM1) mack = 1'b0;
        if (bus.I_VEC_WR) mvbase = int'(bus.I_VD) / 8;
        for (int c = 0; c < 4; c++) mreq[c] = bus.I_REQ[c];
        mpend = np;
        mserv = ns;
    endtask

    task automatic check_model(string tag);
        int hp, hs;
        bit elig;
        logic [7:0] exp_d;
        hp    = first_of(mpend);
        hs    = first_of(mserv);
        elig  = (hp != 99) && (hp < hs);
        exp_d = 8'(mvbase * 8 + mack_ch * 2);
        cmp({tag, "_int_n"}, 8'(bus.O_INT_n), 8'(!(bus.I_IEI && elig)));
        cmp({tag, "_ieo"},   8'(bus.O_IEO),
            8'(bus.I_IEI && (hs == 99) && !((hp != 99) && !bus.I_M1_n)));
        cmp({tag, "_doe"},   8'(bus.O_DOE), 8'(bus.I_SPM1 && mack));
        cmp({tag, "_d"},     bus.O_D, exp_d);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(string tag, vec_t v);
        set_in(v);
        @(negedge clk);
        check_model(tag);
        tick();
    endtask

    vec_t tab [27];

    initial begin
        vec_t v;
        logic [3:0] rq;

        // clken req clr vw vd iei m1n spm1 reti | int_n ieo doe d
        tab[0]  = mk(1, 4'h0, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'h48);
        tab[1]  = mk(1, 4'h0, 4'h0, 1, 8'hE0, 1, 1, 0, 0, 1, 1, 0, 8'h48);
        tab[2]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'hE0);
        tab[3]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'hE0);
        tab[4]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'hE0);
        tab[5]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'hE0);
        tab[6]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'hE2);
        tab[7]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'hE2);
        tab[8]  = mk(1, 4'h2, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'hE2);
        tab[9]  = mk(1, 4'h6, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'hE2);
        tab[10] = mk(1, 4'h6, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'hE2);
        tab[11] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'hE2);
        tab[12] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'hE2);
        tab[13] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'hE2);
        tab[14] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'hE0);
        tab[15] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 8'hE0);
        tab[16] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 8'hE0);
        tab[17] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 8'hE0);
        tab[18] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'hE0);
        tab[19] = mk(1, 4'h7, 4'h0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'hE0);
        tab[20] = mk(1, 4'h7, 4'h0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'hE0);
        tab[21] = mk(1, 4'h7, 4'h0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'hE0);
        tab[22] = mk(1, 4'h7, 4'h0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'hE0);
        tab[23] = mk(1, 4'h7, 4'h4, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'hE0);
        tab[24] = mk(1, 4'hF, 4'h8, 0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'hE0);
        tab[25] = mk(1, 4'hF, 4'h0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 8'hE0);
        tab[26] = mk(0, 4'hF, 4'h0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'hE0);

        set_in(mk_in(4'h0, 1, 1, 0, 0));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_int_n", 8'(bus.O_INT_n), 8'h01);
        cmp("rst_doe",   8'(bus.O_DOE),   8'h00);
        cmp("rst_ieo",   8'(bus.O_IEO),   8'h01);
        cmp("rst_d",     bus.O_D,         VEC_RESET & 8'hF8);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            set_in(tab[i]);
            @(negedge clk);
            cmp($sformatf("row%0d_int_n", i), 8'(bus.O_INT_n), 8'(tab[i].e_int_n));
            cmp($sformatf("row%0d_ieo", i),   8'(bus.O_IEO),   8'(tab[i].e_ieo));
            cmp($sformatf("row%0d_doe", i),   8'(bus.O_DOE),   8'(tab[i].e_doe));
            cmp($sformatf("row%0d_d", i),     bus.O_D,         tab[i].e_d);
            tick();
        end

        // Reset asserted while the vector is on the bus.
        step("pre0", mk_in(4'h0, 1, 1, 0, 0));
        step("pre1", mk_in(4'h1, 1, 1, 0, 0));
        step("pre2", mk_in(4'h1, 1, 0, 1, 0));
        set_in(mk_in(4'h1, 1, 0, 1, 0));
        @(negedge clk);
        cmp("mid_ack_doe", 8'(bus.O_DOE), 8'h01);
        cmp("mid_ack_d",   bus.O_D,       8'hE0);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_doe",   8'(bus.O_DOE),   8'h00);
        cmp("arst_int_n", 8'(bus.O_INT_n), 8'h01);
        cmp("arst_ieo",   8'(bus.O_IEO),   8'h01);
        cmp("arst_d",     bus.O_D,         VEC_RESET & 8'hF8);
        model_reset();
        set_in(mk_in(4'h0, 1, 1, 0, 0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RETI with IEI low is ignored; RETI and ack in the same cycle.
        step("s0", mk_in(4'h2, 1, 1, 0, 0));
        step("s1", mk_in(4'h2, 1, 1, 0, 0));
        step("s2", mk_in(4'h2, 1, 0, 1, 0));
        step("s3", mk_in(4'h2, 1, 0, 1, 0));
        step("s4", mk_in(4'h2, 0, 1, 0, 1));
        set_in(mk_in(4'h2, 1, 1, 0, 0));
        @(negedge clk);
        check_model("s5");
        cmp("reti_iei0_ieo", 8'(bus.O_IEO), 8'h00);
        tick();
        step("s6", mk_in(4'h3, 1, 1, 0, 0));
        step("s7", mk_in(4'h3, 1, 1, 0, 0));
        step("s8", mk_in(4'h3, 1, 0, 1, 1));
        set_in(mk_in(4'h3, 1, 0, 1, 0));
        @(negedge clk);
        check_model("s9");
        cmp("reti_ack_d",   bus.O_D,       8'h48);
        cmp("reti_ack_doe", 8'(bus.O_DOE), 8'h01);
        tick();
        step("s10", mk_in(4'h3, 1, 1, 0, 1));
        set_in(mk_in(4'h3, 1, 1, 0, 0));
        @(negedge clk);
        check_model("s11");
        cmp("all_retired_ieo",   8'(bus.O_IEO),   8'h01);
        cmp("all_retired_int_n", 8'(bus.O_INT_n), 8'h01);
        tick();

        rq = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = rq ^ 4'($urandom_range(0, 15));
            v          = mk_in(rq, 1, 1, 0, 0);
            v.clken    = ($urandom_range(0, 9) < 8);
            v.iei      = ($urandom_range(0, 9) < 8);
            v.spm1     = ($urandom_range(0, 3) == 0);
            v.m1_n     = v.spm1 ? 1'b0 : 1'($urandom_range(0, 1));
            v.reti     = ($urandom_range(0, 7) == 0);
            v.clr      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            v.vec_wr   = ($urandom_range(0, 49) == 0);
            v.vd       = 8'($urandom_range(0, 255));
            step("rnd", v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
